butterfly_pipe: RTL and testbench

- Pipelined, parametrised radix-2 DIT butterfly: a_o = a + W·b, b_o = a − W·b.
- Successor to the combinational butterfly, adding:
  - valid/ready streaming with backpressure;
  - a fixed 3-cycle latency;
  - convergent-free round-half-up;
  - output saturation with a sticky saturation counter;
  - per-beat inverse (conjugate twiddle) and divide-by-2 scaling modes.
- Sits between the twiddle ROM/address generator and the stage buffer in the streaming FFT datapath.

---
 rtl/butterfly_pipe.sv | 153 +++++++++++++++
 tb/tb_butterfly_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/butterfly_pipe.sv
// Pipelined radix-2 DIT butterfly: a_o = a + W*b, b_o = a - W*b.
// Three register stages (capture / rotate / add-scale-saturate) behind a single
// global stall, with per-beat inverse and divide-by-2 modes and a sticky
// saturation event counter.
module butterfly_pipe #(
    parameter int DATA_WIDTH    = 16,
    parameter int FRAC_BITS     = 15,
    parameter int TWID_WIDTH    = FRAC_BITS + 2,
    parameter int SAT_CNT_WIDTH = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [1:0][TWID_WIDTH-1:0]     twid_i,
    input  logic [1:0][DATA_WIDTH-1:0]     a_i,
    input  logic [1:0][DATA_WIDTH-1:0]     b_i,
    input  logic                           inv_i,
    input  logic                           scale_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [1:0][DATA_WIDTH-1:0]     a_o,
    output logic [1:0][DATA_WIDTH-1:0]     b_o,
    output logic                           sat_o,
    output logic [SAT_CNT_WIDTH-1:0]       sat_cnt_o,
    input  logic                           sat_clr_i
);
    localparam int STAGES = 3;
    localparam int WE_W   = TWID_WIDTH + 1;              // negated twiddle never overflows
    localparam int PROD_W = DATA_WIDTH + TWID_WIDTH;
    localparam int SUM_W  = PROD_W + 1;                  // sum of two products
    localparam int ROT_W  = DATA_WIDTH + 2;              // rounded rotated b
    localparam int ADD_W  = DATA_WIDTH + 3;              // a +/- b_rot headroom

    localparam logic signed [SUM_W-1:0] RND     = SUM_W'(64'sd1 <<< (FRAC_BITS - 1));
    localparam logic signed [ADD_W-1:0] ADD_ONE = ADD_W'(1);
    localparam logic signed [ADD_W-1:0] SAT_MAX = ADD_W'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ADD_W-1:0] SAT_MIN = ~SAT_MAX;

    // Stage valid bits; vld_q[STAGES] is the output beat.
    logic [STAGES:1] vld_q;
    logic            advance;

    // S1: captured operands and mode bits
    logic [1:0][TWID_WIDTH-1:0] twid_s1_q;
    logic [1:0][DATA_WIDTH-1:0] a_s1_q, b_s1_q;
    logic                       inv_s1_q, scale_s1_q;

    // S2: rotated b plus pass-through a
    logic [1:0][DATA_WIDTH-1:0] a_s2_q;
    logic [1:0][ROT_W-1:0]      rot_s2_q, rot_d;
    logic                       scale_s2_q;

    // S3: final results
    logic [1:0][DATA_WIDTH-1:0] a_s3_q, b_s3_q, a_d, b_d;
    logic                       sat_s3_q, sat_d;
    logic [1:0]                 clip_p, clip_m;

    logic [SAT_CNT_WIDTH-1:0]   sat_cnt_q, sat_cnt_d;

    // Optional halve (round half up), then clip to the output range.
    // Returns {clipped, value}.
    function automatic logic [DATA_WIDTH:0] scale_sat(input logic signed [ADD_W-1:0] v,
                                                      input logic                    sc);
        logic signed [ADD_W-1:0] s;
        s = sc ? ((v + ADD_ONE) >>> 1) : v;
        if (s > SAT_MAX)      return {1'b1, SAT_MAX[DATA_WIDTH-1:0]};
        else if (s < SAT_MIN) return {1'b1, SAT_MIN[DATA_WIDTH-1:0]};
        return {1'b0, s[DATA_WIDTH-1:0]};
    endfunction

    assign advance     = out_ready_i || !vld_q[STAGES];
    assign in_ready_o  = advance;
    assign out_valid_o = vld_q[STAGES];
    assign a_o         = a_s3_q;
    assign b_o         = b_s3_q;
    assign sat_o       = sat_s3_q;
    assign sat_cnt_o   = sat_cnt_q;

    // Complex rotation b*W (or b*conj(W)) with round-half-up back to Q.FRAC_BITS
    always_comb begin
        logic signed [WE_W-1:0]  wi_eff;
        logic signed [SUM_W-1:0] br_x, bi_x, wr_x, wi_x, re_sum, im_sum;
        wi_eff = WE_W'($signed(twid_s1_q[1]));
        if (inv_s1_q) wi_eff = -wi_eff;
        br_x   = SUM_W'($signed(b_s1_q[0]));
        bi_x   = SUM_W'($signed(b_s1_q[1]));
        wr_x   = SUM_W'($signed(twid_s1_q[0]));
        wi_x   = SUM_W'(wi_eff);
        re_sum = br_x * wr_x - bi_x * wi_x;
        im_sum = br_x * wi_x + bi_x * wr_x;
        rot_d[0] = ROT_W'((re_sum + RND) >>> FRAC_BITS);
        rot_d[1] = ROT_W'((im_sum + RND) >>> FRAC_BITS);
    end

    // Per-component add/sub, scale and saturate
    for (genvar k = 0; k < 2; k++) begin : g_cmp
        logic signed [ADD_W-1:0] a_x, r_x;
        assign a_x = ADD_W'($signed(a_s2_q[k]));
        assign r_x = ADD_W'($signed(rot_s2_q[k]));
        assign {clip_p[k], a_d[k]} = scale_sat(a_x + r_x, scale_s2_q);
        assign {clip_m[k], b_d[k]} = scale_sat(a_x - r_x, scale_s2_q);
    end

    assign sat_d = (|clip_p) | (|clip_m);

    // Pipeline registers: every stage moves together when the output is free
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q      <= '0;
            twid_s1_q  <= '0;
            a_s1_q     <= '0;
            b_s1_q     <= '0;
            inv_s1_q   <= 1'b0;
            scale_s1_q <= 1'b0;
            a_s2_q     <= '0;
            rot_s2_q   <= '0;
            scale_s2_q <= 1'b0;
            a_s3_q     <= '0;
            b_s3_q     <= '0;
            sat_s3_q   <= 1'b0;
        end else if (advance) begin
            vld_q      <= {vld_q[STAGES-1:1], in_valid_i};
            twid_s1_q  <= twid_i;
            a_s1_q     <= a_i;
            b_s1_q     <= b_i;
            inv_s1_q   <= inv_i;
            scale_s1_q <= scale_i;
            a_s2_q     <= a_s1_q;
            rot_s2_q   <= rot_d;
            scale_s2_q <= scale_s1_q;
            a_s3_q     <= a_d;
            b_s3_q     <= b_d;
            sat_s3_q   <= sat_d;
        end
    end

    // Saturation counter next state: clear wins, holds at all-ones
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clr_i)
            sat_cnt_d = '0;
        else if (out_valid_o && out_ready_i && sat_s3_q && !(&sat_cnt_q))
            sat_cnt_d = sat_cnt_q + 1'b1;
    end

    // Saturation counter register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) sat_cnt_q <= '0;
        else         sat_cnt_q <= sat_cnt_d;
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Self-checking bench for butterfly_pipe: directed vectors, stall, reset and
// randomized traffic checked against a scoreboard fed by an arithmetic model.
module tb_butterfly_pipe;
    localparam int DW = 16;
    localparam int FB = 15;
    localparam int TW = FB + 2;
    localparam int CW = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid, in_ready, inv, scale;
    logic               out_valid, out_ready, sat, sat_clr;
    logic [1:0][TW-1:0] twid;
    logic [1:0][DW-1:0] a, b, ao, bo;
    logic [CW-1:0]      sat_cnt;

    always #5 clk = ~clk;

    butterfly_pipe #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .TWID_WIDTH(TW), .SAT_CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .twid_i(twid), .a_i(a), .b_i(b), .inv_i(inv), .scale_i(scale),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .a_o(ao), .b_o(bo), .sat_o(sat), .sat_cnt_o(sat_cnt), .sat_clr_i(sat_clr)
    );

    typedef struct { longint ar, ai, br, bi; bit sat; } exp_t;
    exp_t q[$];

    int     n_chk = 0, n_fail = 0;
    longint exp_cnt = 0;
    bit     prev_stall = 0, last_acc, last_cons, last_stall;
    logic [1:0][DW-1:0] prev_ao, prev_bo;
    logic   prev_sat;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Floor division, so rounding below is exact for negative values too.
    function automatic longint fdiv(input longint x, input longint d);
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction

    // Butterfly in plain integer arithmetic.
    function automatic exp_t model(input longint wr, wi, ar, ai, br, bi, input bit iv, sc);
        longint wie, rr, ri, hi, lo, one;
        longint v[4];
        exp_t e;
        one = (longint'(1) <<< FB);
        hi  = (longint'(1) <<< (DW - 1)) - 1;
        lo  = -(longint'(1) <<< (DW - 1));
        wie = iv ? -wi : wi;
        rr  = fdiv(br * wr - bi * wie + one / 2, one);
        ri  = fdiv(br * wie + bi * wr + one / 2, one);
        v[0] = ar + rr; v[1] = ai + ri; v[2] = ar - rr; v[3] = ai - ri;
        e.sat = 0;
        for (int k = 0; k < 4; k++) begin
            if (sc) v[k] = fdiv(v[k] + 1, 2);
            if (v[k] > hi)      begin v[k] = hi; e.sat = 1; end
            else if (v[k] < lo) begin v[k] = lo; e.sat = 1; end
        end
        e.ar = v[0]; e.ai = v[1]; e.br = v[2]; e.bi = v[3];
        return e;
    endfunction

    task automatic drive(input int wr, wi, ar, ai, br, bi, input bit iv, sc);
        twid[0] = TW'(wr); twid[1] = TW'(wi);
        a[0] = DW'(ar); a[1] = DW'(ai);
        b[0] = DW'(br); b[1] = DW'(bi);
        inv = iv; scale = sc;
    endtask

    task automatic rand_inputs();
        drive(int'($urandom_range(65536)) - 32768, int'($urandom_range(65536)) - 32768,
              int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768,
              int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768,
              1'($urandom_range(1)), 1'($urandom_range(1)));
    endtask

    // One clock: observe handshakes, update the scoreboard, step to the next negedge.
    task automatic tick();
        exp_t e;
        #1;
        last_acc   = in_valid && in_ready;
        last_cons  = out_valid && out_ready;
        last_stall = out_valid && !out_ready;
        if (!rst_n) begin
            q.delete();
            exp_cnt = 0;
        end else begin
            if (last_stall) chk("in_ready_stall", in_ready, 0);
            if (prev_stall) begin
                chk("hold_a", ao, prev_ao);
                chk("hold_b", bo, prev_bo);
                chk("hold_sat", sat, prev_sat);
            end
            if (last_cons) begin
                if (q.size() == 0) chk("spurious_out", out_valid, 0);
                else begin
                    e = q.pop_front();
                    chk("a_re", $signed(ao[0]), e.ar);
                    chk("a_im", $signed(ao[1]), e.ai);
                    chk("b_re", $signed(bo[0]), e.br);
                    chk("b_im", $signed(bo[1]), e.bi);
                    chk("sat",  sat, e.sat);
                    if (e.sat && exp_cnt < (longint'(1) <<< CW) - 1) exp_cnt++;
                end
            end
            if (sat_clr) exp_cnt = 0;
            if (last_acc)
                q.push_back(model($signed(twid[0]), $signed(twid[1]), $signed(a[0]), $signed(a[1]),
                                  $signed(b[0]), $signed(b[1]), inv, scale));
        end
        prev_stall = rst_n && last_stall;
        prev_ao = ao; prev_bo = bo; prev_sat = sat;
        @(posedge clk);
        @(negedge clk);
        chk("sat_cnt", sat_cnt, exp_cnt);
    endtask

    // Single beat through an empty pipe: latency and explicit expected values.
    task automatic directed(input string tag, input int wr, wi, ar, ai, br, bi, input bit iv, sc,
                            input int ear, eai, ebr, ebi, input bit esat);
        int n;
        drive(wr, wi, ar, ai, br, bi, iv, sc);
        in_valid = 1; out_ready = 1;
        tick();
        in_valid = 0;
        n = 1;
        while (!out_valid && n < 10) begin tick(); n++; end
        chk({tag, "_lat"}, n, 3);
        chk({tag, "_ar"}, $signed(ao[0]), ear);
        chk({tag, "_ai"}, $signed(ao[1]), eai);
        chk({tag, "_br"}, $signed(bo[0]), ebr);
        chk({tag, "_bi"}, $signed(bo[1]), ebi);
        chk({tag, "_sat"}, sat, esat);
        tick();
    endtask

    initial begin
        int n, sent, got, t, last, nlow, nv;
        rst_n = 0; in_valid = 0; out_ready = 0; sat_clr = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        rst_n = 1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sat", sat, 0);
        chk("rst_sat_cnt", sat_cnt, 0);
        chk("rst_a_o", ao, 0);
        chk("rst_b_o", bo, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);

        directed("unity",  32768, 0, 16384, 0, 8192, 0, 0, 0, 24576, 0, 8192, 0, 0);
        directed("w45",    23170, -23170, 16384, 0, 16384, 0, 0, 0, 27969, -11585, 4799, 11585, 0);
        directed("satur",  32768, 0, 24576, 0, 24576, 0, 0, 0, 32767, 0, 0, 0, 1);
        chk("satur_cnt", sat_cnt, 1);
        directed("scaled", 32768, 0, 24576, 0, 24576, 0, 0, 1, 24576, 0, 0, 0, 0);
        chk("scaled_cnt", sat_cnt, 1);
        directed("inv1",   0, -32768, 0, 0, 8192, 0, 1, 0, 0, 8192, 0, -8192, 0);
        directed("inv0",   0, -32768, 0, 0, 8192, 0, 0, 0, 0, -8192, 0, 8192, 0);

        // Clear coinciding with a saturated consume: clear wins.
        drive(32768, 0, 24576, 0, 24576, 0, 0, 0);
        in_valid = 1; out_ready = 0;
        tick();
        in_valid = 0;
        n = 1;
        while (!out_valid && n < 10) begin tick(); n++; end
        chk("clr_lat", n, 3);
        tick();
        out_ready = 1; sat_clr = 1;
        tick();
        sat_clr = 0;
        chk("clr_wins", sat_cnt, 0);

        // 8 back-to-back beats with out_ready low for cycles 4..8.
        sent = 0; got = 0; t = 0; last = -1; nlow = 0;
        rand_inputs();
        while ((sent < 8 || got < 8) && t < 60) begin
            in_valid  = (sent < 8);
            out_ready = !(t >= 4 && t <= 8);
            tick();
            if (last_acc) begin sent++; rand_inputs(); end
            if (last_cons) begin got++; last = t; end
            if (last_stall) nlow++;
            t++;
        end
        chk("stall_beats", got, 8);
        chk("stall_cycles", nlow, 5);
        chk("stall_total", last + 1, 16);

        // Reset with 3 beats in flight: nothing stale may come out.
        directed("pre_rst", 32768, 0, 24576, 0, 24576, 0, 0, 0, 32767, 0, 0, 0, 1);
        in_valid = 1; out_ready = 1;
        for (int i = 0; i < 3; i++) begin rand_inputs(); tick(); end
        rst_n = 0; in_valid = 0; out_ready = 0;
        tick();
        rst_n = 1; out_ready = 1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_cnt", sat_cnt, 0);
        nv = 0;
        for (int i = 0; i < 6; i++) begin tick(); nv += int'(out_valid); end
        chk("midrst_no_stale", nv, 0);

        // Random traffic with random backpressure, modes and clears.
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            in_valid  = ($urandom_range(9) < 7);
            out_ready = ($urandom_range(9) < 7);
            sat_clr   = ($urandom_range(19) == 0);
            tick();
        end
        in_valid = 0; out_ready = 1; sat_clr = 0;
        n = 0;
        while (q.size() != 0 && n < 20) begin tick(); n++; end
        chk("drain_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
